// File: rtl/calc_sequencer.sv
// Calculator control sequencer: turns key strobes into operand-buffer pulses, opcode and display select.
// Optional idle auto-clear of RESULT/ERROR is enabled by defining CALC_AUTO_CLEAR_EN.
module calc_sequencer #(
  parameter int          DIGITS_MAX     = 3,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       digit_strobe,
  input  logic       op_strobe,
  input  logic [2:0] op_code_in,
  input  logic       enter_strobe,
  input  logic       clear_strobe,
  input  logic       alu_o_flag,
  output logic       store_dig,
  output logic       enter,
  output logic       result_ready,
  output logic [2:0] opcode,
  output logic [1:0] disp_sel,
  output logic       err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OP1    = 3'd1,
    S_OPWAIT = 3'd2,
    S_OP2    = 3'd3,
    S_EXEC   = 3'd4,
    S_RESULT = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam int             CW      = $clog2(DIGITS_MAX + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIGITS_MAX);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  state_t        state_r, nxt_state_s;
  logic [CW-1:0] cnt_r, nxt_cnt_s;
  logic [2:0]    opcode_r, nxt_opcode_s;
  logic          store_dig_r, enter_r, result_ready_r, err_r;
  logic [1:0]    disp_sel_r, disp_s;
  logic          store_s, enter_s;
  logic          clr_s, timeout_s, dig_s, op_s, ent_s, any_strobe_s;

  // Only the highest-priority strobe of a cycle survives.
  assign ent_s        = enter_strobe;
  assign op_s         = op_strobe & ~enter_strobe;
  assign dig_s        = digit_strobe & ~op_strobe & ~enter_strobe;
  assign any_strobe_s = digit_strobe | op_strobe | enter_strobe | clear_strobe;
  assign clr_s        = clear_strobe | timeout_s;

`ifdef CALC_AUTO_CLEAR_EN
  logic [23:0] tmo_r;
  logic        parked_s;

  assign parked_s  = (state_r == S_RESULT) || (state_r == S_ERROR);
  assign timeout_s = parked_s && !any_strobe_s && (tmo_r == (TIMEOUT_CYCLES - 24'd1));

  // Idle-cycle counter while parked in RESULT or ERROR.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tmo_r <= 24'd0;
    end else if (parked_s && !any_strobe_s && !timeout_s) begin
      tmo_r <= tmo_r + 24'd1;
    end else begin
      tmo_r <= 24'd0;
    end
  end
`else
  logic unused_tmo_s;

  assign timeout_s    = 1'b0;
  assign unused_tmo_s = ^{TIMEOUT_CYCLES, any_strobe_s};
`endif

  // Next-state, operand bookkeeping and pulse decode.
  always_comb begin
    nxt_state_s  = state_r;
    nxt_cnt_s    = cnt_r;
    nxt_opcode_s = opcode_r;
    store_s      = 1'b0;
    enter_s      = 1'b0;
    if (clr_s) begin
      nxt_state_s  = S_IDLE;
      nxt_cnt_s    = '0;
      nxt_opcode_s = 3'd0;
    end else begin
      case (state_r)
        S_IDLE, S_OPWAIT, S_RESULT: begin
          if (dig_s) begin
            store_s     = 1'b1;
            nxt_cnt_s   = CNT_ONE;
            nxt_state_s = (state_r == S_OPWAIT) ? S_OP2 : S_OP1;
          end else if (op_s && (state_r != S_IDLE)) begin
            // From RESULT the displayed result is pushed as operand1.
            nxt_opcode_s = op_code_in;
            enter_s      = (state_r == S_RESULT);
            nxt_cnt_s    = '0;
            nxt_state_s  = S_OPWAIT;
          end else begin
            nxt_state_s = state_r;
          end
        end
        S_OP1, S_OP2: begin
          if (ent_s && (state_r == S_OP2)) begin
            nxt_state_s = S_EXEC;
          end else if (op_s && (state_r == S_OP1)) begin
            nxt_opcode_s = op_code_in;
            enter_s      = 1'b1;
            nxt_cnt_s    = '0;
            nxt_state_s  = S_OPWAIT;
          end else if (dig_s && (cnt_r < CNT_MAX)) begin
            store_s   = 1'b1;
            nxt_cnt_s = cnt_r + CNT_ONE;
          end else begin
            nxt_state_s = state_r;
          end
        end
        S_EXEC:  nxt_state_s = alu_o_flag ? S_ERROR : S_RESULT;
        S_ERROR: nxt_state_s = S_ERROR;
        default: begin
          nxt_state_s  = S_IDLE;
          nxt_cnt_s    = '0;
          nxt_opcode_s = 3'd0;
        end
      endcase
    end
  end

  // Display source follows the state being entered so it lines up with state.
  always_comb begin
    case (nxt_state_s)
      S_RESULT: disp_s = 2'd1;
      S_ERROR:  disp_s = 2'd2;
      default:  disp_s = 2'd0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r        <= S_IDLE;
      cnt_r          <= '0;
      opcode_r       <= 3'd0;
      store_dig_r    <= 1'b0;
      enter_r        <= 1'b0;
      result_ready_r <= 1'b0;
      disp_sel_r     <= 2'd0;
      err_r          <= 1'b0;
    end else begin
      state_r        <= nxt_state_s;
      cnt_r          <= nxt_cnt_s;
      opcode_r       <= nxt_opcode_s;
      store_dig_r    <= store_s;
      enter_r        <= enter_s;
      result_ready_r <= (nxt_state_s == S_EXEC);
      disp_sel_r     <= disp_s;
      err_r          <= (nxt_state_s == S_ERROR);
    end
  end

  assign store_dig    = store_dig_r;
  assign enter        = enter_r;
  assign result_ready = result_ready_r;
  assign opcode       = opcode_r;
  assign disp_sel     = disp_sel_r;
  assign err          = err_r;
  assign state        = state_r;

endmodule
